dmem_mmio_bridge: RTL and testbench

//  Data-side memory system directly downstream of the core's M-stage port (dmem_addr/wdata/we/type -> dmem_data).

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_timer.sv | 81 ++++++++
 rtl/dmem_mmio_bridge.sv | 161 ++++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_pkg
// Purpose : Access-type encodings, MMIO offsets and lane helpers for the
//           data-side memory bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] c_TYPE_B  = 3'b000;
  localparam logic [2:0] c_TYPE_H  = 3'b001;
  localparam logic [2:0] c_TYPE_W  = 3'b010;
  localparam logic [2:0] c_TYPE_BU = 3'b100;
  localparam logic [2:0] c_TYPE_HU = 3'b101;

  localparam logic [5:0] c_OFF_MTIME_LO = 6'h00;
  localparam logic [5:0] c_OFF_MTIME_HI = 6'h04;
  localparam logic [5:0] c_OFF_CMP_LO   = 6'h08;
  localparam logic [5:0] c_OFF_CMP_HI   = 6'h0C;
  localparam logic [5:0] c_OFF_GPIO_OUT = 6'h10;
  localparam logic [5:0] c_OFF_GPIO_IN  = 6'h14;
  localparam logic [5:0] c_OFF_CTRL     = 6'h18;

  localparam int c_CTRL_EN   = 0;
  localparam int c_CTRL_PEND = 1;

  // Reserved encodings (011/110/111) are never aligned, so they always fault.
  function automatic logic is_aligned(input logic [2:0] typ, input logic [1:0] ofs);
    case (typ)
      c_TYPE_B, c_TYPE_BU: is_aligned = 1'b1;
      c_TYPE_H, c_TYPE_HU: is_aligned = ~ofs[0];
      c_TYPE_W:            is_aligned = (ofs == 2'b00);
      default:             is_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] typ, input logic [1:0] ofs);
    case (typ[1:0])
      2'b00:   lane_mask = 4'b0001 << ofs;
      2'b01:   lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_timer.sv
//------------------------------------------------------------------------------
// Module  : dmem_timer
// Purpose : Prescaled 64-bit machine timer with compare, enable and irq.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_timer
  import dmem_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_wdata,
  input  logic        i_wr_mtime_lo,
  input  logic        i_wr_mtime_hi,
  input  logic        i_wr_cmp_lo,
  input  logic        i_wr_cmp_hi,
  input  logic        i_wr_ctrl,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_en,
  output logic        o_irq
);

  localparam int                 c_CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRESCALE - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [63:0]        r_mtime;
  logic [63:0]        r_cmp;
  logic               r_en;
  logic               r_irq;

  logic               w_tick;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [63:0]        w_mtime_inc;
  logic [63:0]        w_mtime_next;
  logic [63:0]        w_cmp_next;
  logic               w_en_next;

  always_comb begin
    w_tick       = r_en && (r_cnt == c_CNT_MAX);
    w_cnt_next   = r_cnt;
    if (r_en) begin
      w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
    end
    w_mtime_inc  = r_mtime + 64'(w_tick);
    // A software write owns its half; the other half keeps the tick result.
    w_mtime_next = {i_wr_mtime_hi ? i_wdata : w_mtime_inc[63:32],
                    i_wr_mtime_lo ? i_wdata : w_mtime_inc[31:0]};
    w_cmp_next   = {i_wr_cmp_hi ? i_wdata : r_cmp[63:32],
                    i_wr_cmp_lo ? i_wdata : r_cmp[31:0]};
    w_en_next    = i_wr_ctrl ? i_wdata[c_CTRL_EN] : r_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mtime <= '0;
      r_cmp   <= '1;
      r_en    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_mtime <= w_mtime_next;
      r_cmp   <= w_cmp_next;
      r_en    <= w_en_next;
      r_irq   <= w_en_next && (w_mtime_next >= w_cmp_next);
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_cmp;
  assign o_en       = r_en;
  assign o_irq      = r_irq;

endmodule

`default_nettype wire

// File: rtl/dmem_mmio_bridge.sv
//------------------------------------------------------------------------------
// Module  : dmem_mmio_bridge
// Purpose : M-stage data port decode to on-chip RAM, timer and GPIO MMIO.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_mmio_bridge
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int          PRESCALE  = 1,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  input  logic              dmem_we,
  input  logic [2:0]        dmem_type,
  output logic [31:0]       dmem_data,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int c_IDX_W = $clog2(RAM_WORDS);

  logic [31:0]        r_ram [RAM_WORDS];
  logic [GPIO_W-1:0]  r_gpio_out;
  logic [GPIO_W-1:0]  r_gpio_s1;
  logic [GPIO_W-1:0]  r_gpio_s2;
  logic               r_bus_err;

  logic               w_ram_hit;
  logic               w_mmio_hit;
  logic               w_err;
  logic [c_IDX_W-1:0] w_idx;
  logic [5:0]         w_off;
  logic [31:0]        w_ram_word;
  logic [31:0]        w_shifted;
  logic [31:0]        w_load;
  logic [31:0]        w_mmio_rd;
  logic [31:0]        w_gpio_out_ext;
  logic [31:0]        w_gpio_in_ext;
  logic [31:0]        w_wdata_lanes;
  logic [3:0]         w_be;
  logic               w_ram_we;
  logic               w_mmio_we;

  logic [63:0]        w_mtime;
  logic [63:0]        w_mtimecmp;
  logic               w_en;
  logic               w_irq;

  assign w_ram_hit  = (dmem_addr[31:c_IDX_W+2] == '0);
  assign w_mmio_hit = (dmem_addr[31:6] == MMIO_BASE[31:6]);
  assign w_err      = !(w_ram_hit || w_mmio_hit)
                   || !is_aligned(dmem_type, dmem_addr[1:0])
                   || (w_mmio_hit && (dmem_type != c_TYPE_W));
  assign w_idx      = dmem_addr[c_IDX_W+1:2];
  assign w_off      = dmem_addr[5:0];
  assign w_ram_we   = dmem_we && !w_err && w_ram_hit;
  assign w_mmio_we  = dmem_we && !w_err && w_mmio_hit;
  assign w_be       = lane_mask(dmem_type, dmem_addr[1:0]);

  // Half and word accesses are aligned whenever they get this far, so one
  // byte-granular shift serves all three sizes.
  always_comb begin
    w_ram_word = r_ram[w_idx];
    w_shifted  = w_ram_word >> {dmem_addr[1:0], 3'b000};
    case (dmem_type[1:0])
      2'b00:   w_load = {24'b0, w_shifted[7:0]};
      2'b01:   w_load = {16'b0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    w_gpio_out_ext               = '0;
    w_gpio_out_ext[GPIO_W-1:0]   = r_gpio_out;
    w_gpio_in_ext                = '0;
    w_gpio_in_ext[GPIO_W-1:0]    = r_gpio_s2;
    case (w_off)
      c_OFF_MTIME_LO: w_mmio_rd = w_mtime[31:0];
      c_OFF_MTIME_HI: w_mmio_rd = w_mtime[63:32];
      c_OFF_CMP_LO:   w_mmio_rd = w_mtimecmp[31:0];
      c_OFF_CMP_HI:   w_mmio_rd = w_mtimecmp[63:32];
      c_OFF_GPIO_OUT: w_mmio_rd = w_gpio_out_ext;
      c_OFF_GPIO_IN:  w_mmio_rd = w_gpio_in_ext;
      c_OFF_CTRL: begin
        w_mmio_rd              = '0;
        w_mmio_rd[c_CTRL_EN]   = w_en;
        w_mmio_rd[c_CTRL_PEND] = w_irq;
      end
      default:        w_mmio_rd = '0;
    endcase
  end

  assign dmem_data = w_err ? 32'h0 : (w_ram_hit ? w_load : w_mmio_rd);

  always_comb begin
    case (dmem_type[1:0])
      2'b00:   w_wdata_lanes = {4{dmem_wdata[7:0]}};
      2'b01:   w_wdata_lanes = {2{dmem_wdata[15:0]}};
      default: w_wdata_lanes = dmem_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_ram[w_idx][8*i +: 8] <= w_wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  dmem_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wdata       (dmem_wdata),
    .i_wr_mtime_lo (w_mmio_we && (w_off == c_OFF_MTIME_LO)),
    .i_wr_mtime_hi (w_mmio_we && (w_off == c_OFF_MTIME_HI)),
    .i_wr_cmp_lo   (w_mmio_we && (w_off == c_OFF_CMP_LO)),
    .i_wr_cmp_hi   (w_mmio_we && (w_off == c_OFF_CMP_HI)),
    .i_wr_ctrl     (w_mmio_we && (w_off == c_OFF_CTRL)),
    .o_mtime       (w_mtime),
    .o_mtimecmp    (w_mtimecmp),
    .o_en          (w_en),
    .o_irq         (w_irq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_mmio_we && (w_off == c_OFF_GPIO_OUT)) begin
        r_gpio_out <= dmem_wdata[GPIO_W-1:0];
      end
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
      r_bus_err <= w_err;
    end
  end

  assign gpio_out  = r_gpio_out;
  assign timer_irq = w_irq;
  assign bus_err   = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_dmem_mmio_bridge
// Purpose : Directed self-checking bench for dmem_mmio_bridge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_mmio_bridge;

  localparam logic [31:0] c_MMIO = 32'h1000_0000;
  localparam logic [31:0] c_IDLE = 32'h0000_0000;
  localparam logic [2:0]  c_B  = 3'b000;
  localparam logic [2:0]  c_H  = 3'b001;
  localparam logic [2:0]  c_W  = 3'b010;
  localparam logic [2:0]  c_BU = 3'b100;
  localparam logic [2:0]  c_HU = 3'b101;

  logic        clk;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [2:0]  dmem_type;
  logic [31:0] dmem_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;
  logic        bus_err;

  int n_total = 0;
  int n_bad   = 0;

  dmem_mmio_bridge #(
    .RAM_WORDS (1024),
    .MMIO_BASE (32'h1000_0000),
    .PRESCALE  (1),
    .GPIO_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_type  (dmem_type),
    .dmem_data  (dmem_data),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_type  = t;
    dmem_we    = 1'b1;
    @(posedge clk);
    #1;
    dmem_we    = 1'b0;
    dmem_addr  = c_IDLE;
    dmem_type  = c_W;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [2:0] t,
                        input logic [31:0] exp);
    dmem_addr = a;
    dmem_type = t;
    #1;
    check_eq(tag, dmem_data, exp);
    dmem_addr = c_IDLE;
    dmem_type = c_W;
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_addr  = c_IDLE;
    dmem_wdata = '0;
    dmem_we    = 1'b0;
    dmem_type  = c_W;
    gpio_in    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
    check_eq("rst_irq", {31'b0, timer_irq}, 32'h0);
    check_eq("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rd_chk("rst_mtime_lo", c_MMIO + 32'h00, c_W, 32'h0);
    rd_chk("rst_cmp_lo", c_MMIO + 32'h08, c_W, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", c_MMIO + 32'h18, c_W, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads from a stored word
    bus_write(32'h10, 32'h1122_3344, c_W);
    rd_chk("lb_13", 32'h13, c_B, 32'h11);
    rd_chk("lhu_12", 32'h12, c_HU, 32'h1122);
    rd_chk("lw_10", 32'h10, c_W, 32'h1122_3344);
    rd_chk("lbu_11", 32'h11, c_BU, 32'h33);
    rd_chk("lh_10", 32'h10, c_H, 32'h3344);
    rd_chk("lh_11_misal", 32'h11, c_H, 32'h0);

    // Sub-word stores merge into existing lanes
    bus_write(32'h20, 32'hFFFF_FFFF, c_W);
    bus_write(32'h21, 32'h0000_00AA, c_B);
    rd_chk("sb_21", 32'h20, c_W, 32'hFFFF_AAFF);
    bus_write(32'h22, 32'h0000_5566, c_H);
    rd_chk("sh_22", 32'h20, c_W, 32'h5566_AAFF);

    // Misaligned and unmapped accesses
    bus_write(32'h0, 32'hCAFE_F00D, c_W);
    check_eq("no_err_idle", {31'b0, bus_err}, 32'h0);
    dmem_addr = 32'h6;
    dmem_type = c_W;
    #1;
    check_eq("lw_6_data", dmem_data, 32'h0);
    @(posedge clk);
    #1;
    check_eq("lw_6_err", {31'b0, bus_err}, 32'h1);
    dmem_addr = c_IDLE;
    @(posedge clk);
    #1;
    check_eq("err_pulse_end", {31'b0, bus_err}, 32'h0);
    bus_write(32'h8000_0000, 32'hDEAD_BEEF, c_W);
    check_eq("unmapped_err", {31'b0, bus_err}, 32'h1);
    rd_chk("unmapped_nowr", 32'h0, c_W, 32'hCAFE_F00D);
    bus_write(c_MMIO + 32'h10, 32'h0000_0077, c_B);
    check_eq("mmio_sb_err", {31'b0, bus_err}, 32'h1);
    check_eq("mmio_sb_drop", {24'b0, gpio_out}, 32'h0);

    // Timer compare and irq
    bus_write(c_MMIO + 32'h08, 32'd5, c_W);
    bus_write(c_MMIO + 32'h0C, 32'd0, c_W);
    bus_write(c_MMIO + 32'h18, 32'd1, c_W);
    repeat (4) @(posedge clk);
    #1;
    check_eq("irq_before_5", {31'b0, timer_irq}, 32'h0);
    rd_chk("mtime_4", c_MMIO + 32'h00, c_W, 32'd4);
    @(posedge clk);
    #1;
    check_eq("irq_at_5", {31'b0, timer_irq}, 32'h1);
    rd_chk("mtime_5", c_MMIO + 32'h00, c_W, 32'd5);
    rd_chk("ctrl_pend", c_MMIO + 32'h18, c_W, 32'h3);
    bus_write(c_MMIO + 32'h08, 32'd100, c_W);
    check_eq("irq_cleared", {31'b0, timer_irq}, 32'h0);

    // 64-bit carry and write-vs-tick priority
    bus_write(c_MMIO + 32'h18, 32'd0, c_W);
    bus_write(c_MMIO + 32'h00, 32'hFFFF_FFFF, c_W);
    bus_write(c_MMIO + 32'h04, 32'h0, c_W);
    bus_write(c_MMIO + 32'h18, 32'd1, c_W);
    rd_chk("mtime_pre_carry", c_MMIO + 32'h00, c_W, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rd_chk("carry_lo", c_MMIO + 32'h00, c_W, 32'h0);
    rd_chk("carry_hi", c_MMIO + 32'h04, c_W, 32'h1);
    bus_write(c_MMIO + 32'h00, 32'd7, c_W);
    rd_chk("wr_wins_lo", c_MMIO + 32'h00, c_W, 32'd7);
    rd_chk("wr_keeps_hi", c_MMIO + 32'h04, c_W, 32'h1);

    // GPIO
    bus_write(c_MMIO + 32'h10, 32'h0000_00A5, c_W);
    check_eq("gpio_out", {24'b0, gpio_out}, 32'hA5);
    rd_chk("gpio_out_rd", c_MMIO + 32'h10, c_W, 32'hA5);
    gpio_in = 8'h3C;
    @(posedge clk);
    #1;
    rd_chk("gpio_in_1edge", c_MMIO + 32'h14, c_W, 32'h0);
    @(posedge clk);
    #1;
    rd_chk("gpio_in_2edge", c_MMIO + 32'h14, c_W, 32'h3C);
    bus_write(c_MMIO + 32'h14, 32'hFF, c_W);
    check_eq("gpio_in_wr_noerr", {31'b0, bus_err}, 32'h0);
    rd_chk("gpio_in_ro", c_MMIO + 32'h14, c_W, 32'h3C);

    // Asynchronous reset mid-run
    check_eq("irq_pre_rst", {31'b0, timer_irq}, 32'h1);
    dmem_addr = 32'h8000_0000;
    @(posedge clk);
    #1;
    check_eq("err_pre_rst", {31'b0, bus_err}, 32'h1);
    dmem_addr = c_IDLE;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_gpio_out", {24'b0, gpio_out}, 32'h0);
    check_eq("arst_irq", {31'b0, timer_irq}, 32'h0);
    check_eq("arst_bus_err", {31'b0, bus_err}, 32'h0);
    rd_chk("arst_mtime_lo", c_MMIO + 32'h00, c_W, 32'h0);
    rd_chk("arst_mtime_hi", c_MMIO + 32'h04, c_W, 32'h0);
    rd_chk("arst_cmp_hi", c_MMIO + 32'h0C, c_W, 32'hFFFF_FFFF);
    rd_chk("arst_ctrl", c_MMIO + 32'h18, c_W, 32'h0);
    rd_chk("arst_gpio_in", c_MMIO + 32'h14, c_W, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rd_chk("post_rst_mtime", c_MMIO + 32'h00, c_W, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
